fanout_tree_pipe: RTL and testbench

Parametrised, pipelined 1-to-2^LEVELS broadcast tree: a single input word is replicated through LEVELS registered binary levels of `fanout_node` cells onto N = 2^LEVELS leaf outputs. A per-leaf enable mask travels with each word, so only selected leaves see a valid. A global hold stalls the whole pipeline. The block is the clocked, generalised successor to the fixed combinational 1-to-8 cone test structures, and serves both as real design logic and as a schematic-viewer test case with depth and width as parameters.

---
 rtl/fanout_pkg.sv | 17 +
 rtl/fanout_tree_pipe_if.sv | 31 +++
 rtl/fanout_node.sv | 76 +++++++
 rtl/fanout_tree_pipe.sv | 90 +++++++++
 tb/tb_fanout_tree_pipe.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fanout_pkg.sv
// Shared helpers for the pipelined broadcast tree: leaf count and a ceil-log2.
package fanout_pkg;

  function automatic int unsigned leaf_count(input int unsigned levels);
    return 32'd1 << levels;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fanout_tree_pipe_if.sv
// Bus bundle of the broadcast tree: input word + leaf mask in, per-leaf words out.
interface fanout_tree_pipe_if
  import fanout_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEVELS = 3,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned N = leaf_count(LEVELS);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic [N-1:0]         leaf_en;
  logic                 in_ready;
  logic                 hold;
  logic [N-1:0]         out_valid;
  logic [N*WIDTH-1:0]   out_data;
  logic                 busy;
  logic [CNT_W-1:0]     xfer_count;

  modport master (
    output in_valid, in_data, leaf_en, hold,
    input  in_ready, out_valid, out_data, busy, xfer_count
  );

  modport slave (
    input  in_valid, in_data, leaf_en, hold,
    output in_ready, out_valid, out_data, busy, xfer_count
  );

endinterface

// File: rtl/fanout_node.sv
// One binary tree node: splits the incoming mask and registers a pruned copy of
// the word for each half.
module fanout_node
  import fanout_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MASK_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [MASK_W-1:0]   in_mask,
  output logic                out1_valid,
  output logic [WIDTH-1:0]    out1_data,
  output logic [MASK_W/2-1:0] out1_mask,
  output logic                out2_valid,
  output logic [WIDTH-1:0]    out2_data,
  output logic [MASK_W/2-1:0] out2_mask
);

  localparam int unsigned HALF_W = MASK_W / 2;

  logic              v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0]  d1_q, d1_d, d2_q, d2_d;
  logic [HALF_W-1:0] m1_q, m1_d, m2_q, m2_d;

  // Lower mask half feeds out1 (lower leaf indices); data only loads with a valid.
  always_comb begin
    v1_d = v1_q;
    d1_d = d1_q;
    m1_d = m1_q;
    v2_d = v2_q;
    d2_d = d2_q;
    m2_d = m2_q;
    if (!hold) begin
      v1_d = in_valid & (|in_mask[HALF_W-1:0]);
      v2_d = in_valid & (|in_mask[MASK_W-1:HALF_W]);
      if (v1_d) begin
        d1_d = in_data;
        m1_d = in_mask[HALF_W-1:0];
      end
      if (v2_d) begin
        d2_d = in_data;
        m2_d = in_mask[MASK_W-1:HALF_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      m1_q <= '0;
      v2_q <= 1'b0;
      d2_q <= '0;
      m2_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
      m1_q <= m1_d;
      v2_q <= v2_d;
      d2_q <= d2_d;
      m2_q <= m2_d;
    end
  end

  assign out1_valid = v1_q;
  assign out1_data  = d1_q;
  assign out1_mask  = m1_q;
  assign out2_valid = v2_q;
  assign out2_data  = d2_q;
  assign out2_mask  = m2_q;

endmodule

// File: rtl/fanout_tree_pipe.sv
// Pipelined 1-to-2^LEVELS broadcast tree of fanout_node levels with per-leaf
// enable mask, global hold and a wrapping accepted-word counter.
module fanout_tree_pipe
  import fanout_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEVELS = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fanout_tree_pipe_if.slave bus
);

  localparam int unsigned N     = leaf_count(LEVELS);
  localparam int unsigned SLOTS = 2 * N - 2;

  // Node outputs of every level packed back to back; level k starts at slot 2^(k+1)-2.
  // Each level's output masks total exactly N bits, so level k owns m_all[k*N +: N].
  logic                   accept_c;
  logic [SLOTS-1:0]       v_all;
  logic [SLOTS*WIDTH-1:0] d_all;
  logic [LEVELS*N-1:0]    m_all;
  logic [N-1:0]           unused_leaf_mask;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign accept_c = bus.in_valid & ~bus.hold & (|bus.leaf_en);

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NODES = 32'd1 << k;
    localparam int unsigned MW    = N >> k;
    localparam int unsigned HW    = MW / 2;
    localparam int unsigned OBASE = 2 * NODES - 2;

    for (genvar j = 0; j < NODES; j++) begin : g_node
      logic             pv;
      logic [WIDTH-1:0] pd;
      logic [MW-1:0]    pm;

      if (k == 0) begin : g_root
        assign pv = accept_c;
        assign pd = bus.in_data;
        assign pm = bus.leaf_en;
      end else begin : g_child
        localparam int unsigned IBASE = NODES - 2 + j;
        localparam int unsigned MOFS  = (k - 1) * N + j * MW;
        assign pv = v_all[IBASE];
        assign pd = d_all[IBASE*WIDTH +: WIDTH];
        assign pm = m_all[MOFS +: MW];
      end

      fanout_node #(
        .WIDTH  (WIDTH),
        .MASK_W (MW)
      ) u_node (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (bus.hold),
        .in_valid   (pv),
        .in_data    (pd),
        .in_mask    (pm),
        .out1_valid (v_all[OBASE + 2*j]),
        .out1_data  (d_all[(OBASE + 2*j)*WIDTH +: WIDTH]),
        .out1_mask  (m_all[k*N + 2*j*HW +: HW]),
        .out2_valid (v_all[OBASE + 2*j + 1]),
        .out2_data  (d_all[(OBASE + 2*j + 1)*WIDTH +: WIDTH]),
        .out2_mask  (m_all[k*N + (2*j + 1)*HW +: HW])
      );
    end
  end

  // Leaf-level half-masks select nothing further down.
  assign unused_leaf_mask = m_all[(LEVELS-1)*N +: N];

  always_comb begin
    cnt_d = cnt_q + CNT_W'(accept_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.in_ready   = ~bus.hold;
  assign bus.out_valid  = v_all[N-2 +: N];
  assign bus.out_data   = d_all[(N-2)*WIDTH +: N*WIDTH];
  assign bus.busy       = |v_all;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_fanout_tree_pipe.sv
// Scoreboard bench for fanout_tree_pipe (LEVELS=3, WIDTH=8, CNT_W=4).
module tb_fanout_tree_pipe;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned LEVELS = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned N      = 8;

  typedef struct {
    logic [N-1:0]       mask;
    logic [N*WIDTH-1:0] data;
    int                 due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t               sb[$];
  exp_t               mon_e;
  logic [N*WIDTH-1:0] model_data;
  logic [CNT_W-1:0]   model_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fanout_tree_pipe_if #(.WIDTH(WIDTH), .LEVELS(LEVELS), .CNT_W(CNT_W)) bus ();

  fanout_tree_pipe #(.WIDTH(WIDTH), .LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drive one cycle of inputs; model accepts, leaf retention, count and hold delay.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                       input logic [N-1:0] m, input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.leaf_en  = m;
    bus.hold     = h;
    if (h) begin
      for (int i = 0; i < sb.size(); i++) sb[i].due = sb[i].due + 1;
    end else if (v && m != '0 && rst_n) begin
      for (int i = 0; i < N; i++)
        if (m[i]) model_data[i*WIDTH +: WIDTH] = d;
      e.mask = m;
      e.data = model_data;
      e.due  = cyc + LEVELS;
      sb.push_back(e);
      model_cnt = model_cnt + 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    sb.delete();
    model_data = '0;
    model_cnt  = '0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: every leaf delivery must match the oldest expected word on its due cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_delivery due_cycle=%0d now=%0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (bus.out_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid got out_valid=%h want 00 cycle=%0d", bus.out_valid, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (bus.out_valid !== mon_e.mask || bus.out_data !== mon_e.data || cyc != mon_e.due) begin
            failures++;
            $display("FAIL delivery got valid=%h data=%h cycle=%0d want valid=%h data=%h cycle=%0d",
                     bus.out_valid, bus.out_data, cyc, mon_e.mask, mon_e.data, mon_e.due);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.leaf_en  = 8'hFF;
    bus.hold     = 1'b0;
    model_data   = '0;
    model_cnt    = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== '0 || bus.out_data !== '0 || bus.busy !== 1'b0 || bus.xfer_count !== '0) begin
        failures++;
        $display("FAIL reset_state got valid=%h data=%h busy=%b cnt=%h want all zero",
                 bus.out_valid, bus.out_data, bus.busy, bus.xfer_count);
      end
      checks++;
      if (bus.in_ready !== ~bus.hold) begin
        failures++;
        $display("FAIL reset_in_ready got %b want %b", bus.in_ready, ~bus.hold);
      end
      if (i == 1) bus.hold = 1'b1;
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
  endtask

  task automatic test_single();
    int c0;
    drive(1'b1, 8'hA5, 8'hFF, 1'b0);
    c0 = cyc;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_c0 got %b want 0", bus.busy);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.busy !== ((cyc - c0) >= 1 && (cyc - c0) <= 3)) begin
        failures++;
        $display("FAIL single_busy got %b cycle_offset=%0d", bus.busy, cyc - c0);
      end
      if (cyc - c0 == 3) begin
        checks++;
        if (bus.out_valid !== 8'hFF || bus.out_data !== {8{8'hA5}}) begin
          failures++;
          $display("FAIL single_leaves got valid=%h data=%h want FF/all A5", bus.out_valid, bus.out_data);
        end
      end
    end
    checks++;
    if (bus.xfer_count !== 4'd1) begin
      failures++;
      $display("FAIL single_count got %0d want 1", bus.xfer_count);
    end
  endtask

  task automatic test_mask_retain();
    logic [N*WIDTH-1:0] od;
    drive(1'b1, 8'h11, 8'hFF, 1'b0);
    drive(1'b1, 8'h3C, 8'h05, 1'b0);
    idle(5);
    @(negedge clk);
    od = bus.out_data;
    checks++;
    if (od[0 +: 8] !== 8'h3C || od[16 +: 8] !== 8'h3C || od[8 +: 8] !== 8'h11 || od[56 +: 8] !== 8'h11) begin
      failures++;
      $display("FAIL mask_retain got data=%h want leaves0,2=3C others=11", od);
    end
  endtask

  task automatic test_back_to_back();
    for (int w = 1; w <= 4; w++) drive(1'b1, WIDTH'(w), 8'h81, 1'b0);
    idle(6);
    checks++;
    if (sb.size() != 0 || bus.xfer_count !== model_cnt) begin
      failures++;
      $display("FAIL back_to_back got pending=%0d cnt=%0d want 0 pending cnt=%0d",
               sb.size(), bus.xfer_count, model_cnt);
    end
  endtask

  task automatic test_hold();
    int c0;
    logic [CNT_W-1:0] cnt0;
    cnt0 = model_cnt;
    drive(1'b1, 8'h5E, 8'hFF, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h77, 8'hFF, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_in_ready got %b want 0", bus.in_ready);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      if (cyc - c0 == 5) begin
        checks++;
        if (bus.out_valid !== 8'hFF || bus.out_data !== {8{8'h5E}}) begin
          failures++;
          $display("FAIL hold_delivery got valid=%h data=%h want FF/all 5E", bus.out_valid, bus.out_data);
        end
      end
    end
    checks++;
    if (bus.xfer_count !== cnt0 + 4'd1) begin
      failures++;
      $display("FAIL hold_count got %0d want %0d", bus.xfer_count, cnt0 + 4'd1);
    end
  endtask

  task automatic test_drop_wrap_reset();
    logic [CNT_W-1:0] cnt0;
    cnt0 = model_cnt;
    drive(1'b1, 8'h99, 8'h00, 1'b0);
    idle(5);
    checks++;
    if (bus.xfer_count !== cnt0) begin
      failures++;
      $display("FAIL zero_mask_count got %0d want %0d", bus.xfer_count, cnt0);
    end
    apply_reset(2);
    for (int i = 0; i < 17; i++)
      drive(1'b1, WIDTH'($urandom_range(0, 255)), N'($urandom_range(1, 255)), 1'b0);
    idle(5);
    checks++;
    if (bus.xfer_count !== 4'd1) begin
      failures++;
      $display("FAIL count_wrap got %0d want 1", bus.xfer_count);
    end
    drive(1'b1, 8'hC3, 8'hFF, 1'b0);
    drive(1'b1, 8'h3C, 8'hFF, 1'b0);
    apply_reset(1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== '0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_flush got valid=%h busy=%b want 00/0", bus.out_valid, bus.busy);
      end
    end
    checks++;
    if (bus.xfer_count !== '0) begin
      failures++;
      $display("FAIL reset_flush_count got %0d want 0", bus.xfer_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask_retain();
    test_back_to_back();
    test_hold();
    test_drop_wrap_reset();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
